sosanh_tichluy: RTL and testbench

Downstream stage of the 4-bit magnitude comparator `sosanh`. Accepts a stream of compare results (flags x = a>b, y = a<b, z = a==b, plus the operands) under a valid/ready handshake. Accumulates per-outcome counts and the running maximum over a fixed window of samples, then presents one result record under a second valid/ready handshake.

---
 rtl/sosanh_tichluy.sv | 101 ++++++++++
 tb/tb_sosanh_tichluy.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sosanh_tichluy.sv
// sosanh_tichluy: windowed accumulator of comparator outcomes with valid/ready in and out.
// SOSANH_ERRCHK_EN: count non-one-hot flag samples in err_cnt instead of priority-decoding them.
module sosanh_tichluy #(
    parameter int WINDOW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    a,
    input  logic [3:0]    b,
    input  logic          x,
    input  logic          y,
    input  logic          z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] gt_cnt,
    output logic [CW-1:0] lt_cnt,
    output logic [CW-1:0] eq_cnt,
    output logic [3:0]    max_val,
    output logic [CW-1:0] err_cnt
);
    localparam int WW = $clog2(WINDOW + 1);
    localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);
    typedef enum logic {COLLECT, REPORT} state_t;
    state_t state, state_nx;
    logic [WW-1:0] win_cnt;
    logic accept, last, flush, ok, is_gt, is_lt, is_eq;
    logic [3:0] big;
    assign in_ready = state == COLLECT;
    assign out_valid = state == REPORT;
    assign accept = in_valid && in_ready && !clr;
    assign last = accept && win_cnt == LAST;
    assign flush = clr || (out_valid && out_ready);
    assign big = x ? a : b;
`ifdef SOSANH_ERRCHK_EN
    logic [CW-1:0] err_q;
    assign ok = $onehot({x, y, z});
    assign is_gt = ok && x;
    assign is_lt = ok && y;
    assign is_eq = ok && z;
    assign err_cnt = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else if (flush)
            err_q <= '0;
        else if (accept && !ok)
            err_q <= err_q + CW'(1);
    end
`else
    // x > y > z priority; all-zero flags fall through to eq
    assign ok = 1'b1;
    assign is_gt = x;
    assign is_lt = !x && y;
    assign is_eq = !x && !y;
    assign err_cnt = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (clr)
            state_nx = COLLECT;
        else if (last)
            state_nx = REPORT;
        else if (out_valid && out_ready)
            state_nx = COLLECT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            max_val <= '0;
        end else if (flush) begin
            win_cnt <= '0;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            max_val <= '0;
        end else if (accept) begin
            win_cnt <= win_cnt + WW'(1);
            if (is_gt)
                gt_cnt <= gt_cnt + CW'(1);
            if (is_lt)
                lt_cnt <= lt_cnt + CW'(1);
            if (is_eq)
                eq_cnt <= eq_cnt + CW'(1);
            if (ok && big > max_val)
                max_val <= big;
        end
    end
endmodule

// File: tb/tb_sosanh_tichluy.sv
// tb_sosanh_tichluy: WINDOW=4 and WINDOW=1 instances on shared stimulus, checked against a window model.
module tb_sosanh_tichluy;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic x = 1'b0, y = 1'b0, z = 1'b0;
    logic ir [2];
    logic ov [2];
    logic [7:0] gt_c [2];
    logic [7:0] lt_c [2];
    logic [7:0] eq_c [2];
    logic [7:0] er_c [2];
    logic [3:0] mx_c [2];
    int n_chk = 0, n_fail = 0;
    int mg [2], ml [2], me [2], mr [2], mm [2], mn [2];
    bit mrep [2];

    always #5 clk = ~clk;

    sosanh_tichluy #(.WINDOW(4), .CW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .x(x), .y(y), .z(z), .out_valid(ov[0]), .out_ready(out_ready),
        .gt_cnt(gt_c[0]), .lt_cnt(lt_c[0]), .eq_cnt(eq_c[0]), .max_val(mx_c[0]), .err_cnt(er_c[0])
    );
    sosanh_tichluy #(.WINDOW(1), .CW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .x(x), .y(y), .z(z), .out_valid(ov[1]), .out_ready(out_ready),
        .gt_cnt(gt_c[1]), .lt_cnt(lt_c[1]), .eq_cnt(eq_c[1]), .max_val(mx_c[1]), .err_cnt(er_c[1])
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    // reference: a window is a list of accepted samples; the record is a summary of that list
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mg[k] = 0; ml[k] = 0; me[k] = 0; mr[k] = 0; mm[k] = 0; mn[k] = 0; mrep[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int wn, lg, ones;
                wn = (k == 0) ? 4 : 1;
                ones = int'(x) + int'(y) + int'(z);
                lg = x ? int'(a) : int'(b);
                if (clr || (mrep[k] && out_ready)) begin
                    mg[k] = 0; ml[k] = 0; me[k] = 0; mr[k] = 0; mm[k] = 0; mn[k] = 0; mrep[k] = 0;
                end else if (!mrep[k] && in_valid) begin
`ifdef SOSANH_ERRCHK_EN
                    if (ones != 1) mr[k]++;
                    else begin
                        if (x) mg[k]++; else if (y) ml[k]++; else me[k]++;
                        if (lg > mm[k]) mm[k] = lg;
                    end
`else
                    if (x) mg[k]++; else if (y) ml[k]++; else me[k]++;
                    if (lg > mm[k]) mm[k] = lg;
`endif
                    mn[k]++;
                    if (mn[k] == wn) mrep[k] = 1;
                end
            end
            #2;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), int'(ir[k]), int'(!mrep[k]));
                chk($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(mrep[k]));
                chk($sformatf("gt_cnt[%0d]", k), int'(gt_c[k]), mg[k]);
                chk($sformatf("lt_cnt[%0d]", k), int'(lt_c[k]), ml[k]);
                chk($sformatf("eq_cnt[%0d]", k), int'(eq_c[k]), me[k]);
                chk($sformatf("err_cnt[%0d]", k), int'(er_c[k]), mr[k]);
                chk($sformatf("max_val[%0d]", k), int'(mx_c[k]), mm[k]);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask
    task automatic putf(input logic v, input int av, input int bv, input logic [2:0] f);
        in_valid = v; a = 4'(av); b = 4'(bv); {x, y, z} = f;
    endtask
    task automatic put(input int av, input int bv);
        putf(1'b1, av, bv, {av > bv, av < bv, av == bv});
    endtask
    task automatic idle;
        in_valid = 1'b0;
    endtask
    task automatic rec0(input string nm, input int v, input int g, input int l, input int e, input int m, input int r);
        chk({nm, " out_valid"}, int'(ov[0]), v);
        chk({nm, " in_ready"}, int'(ir[0]), 1 - v);
        chk({nm, " gt"}, int'(gt_c[0]), g);
        chk({nm, " lt"}, int'(lt_c[0]), l);
        chk({nm, " eq"}, int'(eq_c[0]), e);
        chk({nm, " max"}, int'(mx_c[0]), m);
        chk({nm, " err"}, int'(er_c[0]), r);
    endtask

    initial begin
        int prev;
        repeat (2) tick;
        rec0("reset", 0, 0, 0, 0, 0, 0);
        chk("reset out_valid1", int'(ov[1]), 0);
        rst_n = 1'b1;
        // basic window
        out_ready = 1'b1;
        tick; put(0, 0);
        tick; put(5, 1);
        tick; put(2, 5);
        tick; put(8, 8);
        tick; idle;
        rec0("window", 1, 1, 1, 2, 8, 0);
        tick;
        rec0("after handshake", 0, 0, 0, 0, 0, 0);
        // backpressure with a held upstream sample
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin tick; put(3, 1); end
        tick; put(7, 7);
        for (int i = 0; i < 5; i++) begin
            tick;
            rec0("backpressure", 1, 4, 0, 0, 3, 0);
        end
        out_ready = 1'b1;
        tick;
        rec0("released", 0, 0, 0, 0, 0, 0);
        tick; put(1, 2);
        rec0("held sample first", 0, 0, 0, 1, 7, 0);
        tick; put(1, 2);
        tick; put(1, 2);
        tick; idle;
        rec0("second window", 1, 0, 3, 1, 7, 0);
        tick;
        // clr discards a partial window
        put(1, 2);
        tick; put(3, 2);
        tick; idle; clr = 1'b1;
        tick; clr = 1'b0;
        rec0("clr", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin put(9, 3); tick; end
        idle;
        rec0("after clr", 1, 4, 0, 0, 9, 0);
        tick;
        // asynchronous reset during REPORT
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin put(6, 2); tick; end
        idle;
        rec0("pre-reset report", 1, 4, 0, 0, 6, 0);
        #2 rst_n = 1'b0;
        #1 rec0("async reset", 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        // illegal flag combinations
        putf(1'b1, 1, 3, 3'b110); tick;
        putf(1'b1, 2, 0, 3'b000); tick;
        put(7, 2); tick;
        put(4, 4); tick;
        idle;
`ifdef SOSANH_ERRCHK_EN
        rec0("flags", 1, 1, 0, 1, 7, 2);
`else
        rec0("flags", 1, 2, 0, 2, 7, 0);
`endif
        tick;
        // WINDOW=1 alternates record and accept every cycle
        put(6, 2);
        tick;
        prev = int'(ov[1]);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("w1 toggle", int'(ov[1]), 1 - prev);
            if (ov[1]) chk("w1 one count", int'(gt_c[1]), 1);
            prev = int'(ov[1]);
        end
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int av, bv;
            av = int'($urandom_range(0, 15));
            bv = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
                putf($urandom_range(0, 9) < 7, av, bv, 3'($urandom_range(0, 7)));
            else begin
                put(av, bv);
                in_valid = $urandom_range(0, 9) < 7;
            end
            out_ready = $urandom_range(0, 9) < 6;
            clr = $urandom_range(0, 29) == 0;
            tick;
        end
        idle; clr = 1'b0;
        repeat (2) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
